fbuf_scanout: RTL and testbench

Video scanout stage downstream of `axi4_lite_gpu`. It generates raster timing, reads 8-bit RGB332 pixels from the framebuffer BRAM read port, and expands them to 24-bit RGB. Its output is a DE/HSYNC/VSYNC/RGB stream for the HDMI encoder. `axi4_lite_gpu` owns the BRAM write port; this block owns the read port.

---
 rtl/gpu_pkg.sv | 41 ++++
 rtl/fbuf_scanout_if.sv | 29 ++
 rtl/video_timing_gen.sv | 70 +++++++
 rtl/fbuf_scanout.sv | 136 +++++++++++++
 tb/tb_fbuf_scanout.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: framebuffer widths, video timing presets, pixel expansion.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package gpu_pkg;

   // Framebuffer geometry shared with the register/BRAM-write side of the GPU.
   localparam int GPU_FBUF_ADDR_WIDTH = 19;
   localparam int GPU_FBUF_DATA_WIDTH = 8;

   // One axis of raster timing, all values in pixels (horizontal) or lines (vertical).
   typedef struct packed {
      logic [15:0] active;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } vtiming_t;

   localparam vtiming_t VGA640_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
   localparam vtiming_t VGA480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

   typedef enum logic {
      SCAN_IDLE = 1'b0,
      SCAN_RUN  = 1'b1
   } scan_state_t;

   // Raster control bits carried down the read-latency delay line.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } vctl_t;

   // Replicate the high bits into the low bits so full-scale codes map to 0xFF.
   function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] p);
      return {p[7:5], p[7:5], p[7:6],
              p[4:2], p[4:2], p[4:3],
              {4{p[1:0]}}};
   endfunction

endpackage

// File: rtl/fbuf_scanout_if.sv
// Scanout bus bundle: framebuffer BRAM read port plus the DE/HSYNC/VSYNC/RGB stream.
// Latency: n/a (wires only).
// Backpressure: none; the video stream runs at one pixel per clock and cannot stall.
// Ports: master = scanout (drives read enable/address and video), slave = BRAM/HDMI side.
interface fbuf_scanout_if #(
   parameter int AW = 19,
   parameter int DW = 8
);
   logic          fbuf_en_rd;
   logic [AW-1:0] fbuf_addr;
   logic [DW-1:0] fbuf_data;
   logic          vid_de;
   logic          vid_hsync;
   logic          vid_vsync;
   logic [23:0]   vid_rgb;
   logic          frame_start;

   modport master (
      output fbuf_en_rd, fbuf_addr,
      input  fbuf_data,
      output vid_de, vid_hsync, vid_vsync, vid_rgb, frame_start
   );

   modport slave (
      input  fbuf_en_rd, fbuf_addr,
      output fbuf_data,
      input  vid_de, vid_hsync, vid_vsync, vid_rgb, frame_start
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster h/v counters with active/sync region decode and frame-boundary flags.
// Latency: decode is combinational from the registered counters (cycle 0).
// Backpressure: none; counters advance every clock while run=1 and sit at (0,0) otherwise.
// Ports: clk, rst_n, run in; active, hsync_on, vsync_on (active-high), frame_first, frame_wrap out.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic active,
   output logic hsync_on,
   output logic vsync_on,
   output logic frame_first,
   output logic frame_wrap
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One spare count of headroom so the sync-end bound never aliases to zero.
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_ONE      = HW'(1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ONE      = VW'(1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_q;
   logic [VW-1:0] v_q;
   logic          h_last;
   logic          v_last;

   assign h_last = (h_q == H_LAST);
   assign v_last = (v_q == V_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else if (!run) begin
         h_q <= '0;
         v_q <= '0;
      end else if (h_last) begin
         h_q <= '0;
         v_q <= v_last ? '0 : v_q + V_ONE;
      end else begin
         h_q <= h_q + H_ONE;
      end
   end

   assign active      = (h_q < H_ACT_END) && (v_q < V_ACT_END);
   assign hsync_on    = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
   assign vsync_on    = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
   assign frame_first = (h_q == '0) && (v_q == '0);
   assign frame_wrap  = h_last && v_last;

endmodule

// File: rtl/fbuf_scanout.sv
// Framebuffer scanout: raster timing, BRAM pixel fetch, RGB332->RGB888 video stream.
// Latency: read address at cycle 0; DE/syncs/frame_start/RGB appear FBUF_RD_LATENCY+1 cycles later.
// Backpressure: none; one pixel per clock, frames always run to completion once started.
// Ports: aclk, aresetn, enable, fbuf_base; bus (master) carries BRAM read port and video out.
module fbuf_scanout
   import gpu_pkg::*;
#(
   parameter int FBUF_ADDR_WIDTH = GPU_FBUF_ADDR_WIDTH,
   parameter int FBUF_DATA_WIDTH = GPU_FBUF_DATA_WIDTH,
   parameter int FBUF_RD_LATENCY = 2,
   parameter int H_ACTIVE        = int'(VGA640_H.active),
   parameter int H_FP            = int'(VGA640_H.fp),
   parameter int H_SYNC          = int'(VGA640_H.sync),
   parameter int H_BP            = int'(VGA640_H.bp),
   parameter int V_ACTIVE        = int'(VGA480_V.active),
   parameter int V_FP            = int'(VGA480_V.fp),
   parameter int V_SYNC          = int'(VGA480_V.sync),
   parameter int V_BP            = int'(VGA480_V.bp),
   parameter bit SYNC_POL        = 1'b0
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       enable,
   input  logic [FBUF_ADDR_WIDTH-1:0] fbuf_base,
   fbuf_scanout_if.master             bus
);
   // Control delay: BRAM latency plus the output register on vid_rgb.
   localparam int DLY = FBUF_RD_LATENCY + 1;
   localparam logic [FBUF_ADDR_WIDTH-1:0] ADDR_ONE = FBUF_ADDR_WIDTH'(1);

   scan_state_t                state_q;
   logic                       run;
   logic                       t_active;
   logic                       t_hsync;
   logic                       t_vsync;
   logic                       t_first;
   logic                       t_wrap;
   logic [FBUF_ADDR_WIDTH-1:0] base_q;
   logic [FBUF_ADDR_WIDTH-1:0] offset_q;
   logic [FBUF_ADDR_WIDTH-1:0] addr_q;
   logic [FBUF_ADDR_WIDTH-1:0] cur_offset;
   logic [FBUF_ADDR_WIDTH-1:0] cur_addr;
   logic [FBUF_DATA_WIDTH-1:0] pix;
   logic [23:0]                rgb_q;
   vctl_t                      ctl0;
   vctl_t                      dly_q [DLY];

   assign run = (state_q == SCAN_RUN);

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk         (aclk),
      .rst_n       (aresetn),
      .run         (run),
      .active      (t_active),
      .hsync_on    (t_hsync),
      .vsync_on    (t_vsync),
      .frame_first (t_first),
      .frame_wrap  (t_wrap)
   );

   // On the first pixel of a frame base_q is only being loaded, so the
   // address is taken straight from fbuf_base with a zero offset.
   always_comb begin
      cur_offset = t_first ? '0 : offset_q;
      cur_addr   = (t_first ? fbuf_base : base_q) + cur_offset;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= SCAN_IDLE;
         base_q   <= '0;
         offset_q <= '0;
         addr_q   <= '0;
      end else begin
         case (state_q)
            SCAN_IDLE: begin
               offset_q <= '0;
               addr_q   <= '0;
               if (enable) state_q <= SCAN_RUN;
            end
            SCAN_RUN: begin
               if (t_first) base_q <= fbuf_base;
               if (t_active) begin
                  addr_q   <= cur_addr;
                  offset_q <= cur_offset + ADDR_ONE;
               end
               // enable is only honoured at the frame wrap, so frames never truncate.
               if (t_wrap && !enable) state_q <= SCAN_IDLE;
            end
            default: state_q <= SCAN_IDLE;
         endcase
      end
   end

   // Address holds through blanking and reads as zero while idle.
   assign bus.fbuf_en_rd = run && t_active;
   assign bus.fbuf_addr  = !run ? '0 : (t_active ? cur_addr : addr_q);

   always_comb begin
      ctl0    = '0;
      ctl0.de = run && t_active;
      ctl0.hs = run && t_hsync;
      ctl0.vs = run && t_vsync;
      ctl0.fs = run && t_active && t_first;
   end

   assign pix = bus.fbuf_data;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < DLY; k++) dly_q[k] <= '0;
         rgb_q <= '0;
      end else begin
         dly_q[0] <= ctl0;
         for (int k = 1; k < DLY; k++) dly_q[k] <= dly_q[k-1];
         // Stage DLY-2 lines up with the BRAM data now on fbuf_data.
         rgb_q <= dly_q[DLY-2].de ? rgb332_to_rgb888(pix) : '0;
      end
   end

   assign bus.vid_de      = dly_q[DLY-1].de;
   assign bus.vid_hsync   = dly_q[DLY-1].hs ? SYNC_POL : ~SYNC_POL;
   assign bus.vid_vsync   = dly_q[DLY-1].vs ? SYNC_POL : ~SYNC_POL;
   assign bus.frame_start = dly_q[DLY-1].fs;
   assign bus.vid_rgb     = rgb_q;

endmodule

// File: tb/tb_fbuf_scanout.sv
module tb_fbuf_scanout;

   typedef struct {
      logic        en_in;
      logic [18:0] base_in;
      logic [47:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic [18:0] fbuf_base = '0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   fbuf_scanout_if #(.AW(19), .DW(8)) bus ();

   fbuf_scanout #(
      .FBUF_ADDR_WIDTH (19),
      .FBUF_DATA_WIDTH (8),
      .FBUF_RD_LATENCY (2),
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (1'b0)
   ) dut (
      .aclk      (clk),
      .aresetn   (aresetn),
      .enable    (enable),
      .fbuf_base (fbuf_base),
      .bus       (bus)
   );

   // Behavioural BRAM, two-cycle read latency.
   logic [7:0] mem [0:524287];
   logic [7:0] rd1 = '0;
   logic [7:0] rd2 = '0;
   always @(posedge clk) begin
      if (bus.fbuf_en_rd) rd1 <= mem[bus.fbuf_addr];
      rd2 <= rd1;
   end
   assign bus.fbuf_data = rd2;

   logic [18:0] addr_log [0:511];
   logic        en_log   [0:511];

   function automatic logic [47:0] mk(input logic en, input logic [18:0] a, input logic de,
                                      input logic fs, input logic hs, input logic vs,
                                      input logic [23:0] rgb);
      return {en, a, de, fs, hs, vs, rgb};
   endfunction

   function automatic logic [47:0] outv();
      return {bus.fbuf_en_rd, bus.fbuf_addr, bus.vid_de, bus.frame_start,
              bus.vid_hsync, bus.vid_vsync, bus.vid_rgb};
   endfunction

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic sample();
      @(negedge clk);
      if (cyc >= 0 && cyc < 512) begin
         addr_log[cyc] = bus.fbuf_addr;
         en_log[cyc]   = bus.fbuf_en_rd;
      end
   endtask

   vec_t        tbl [16];
   logic [47:0] idle_v;
   int          hs14, hs_low, vs_low, de_cnt, fs_cnt;

   initial begin
      for (int i = 0; i < 524288; i++) mem[i] = 8'(i);
      mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03; mem[3] = 8'hFF;
      mem[4] = 8'h00; mem[5] = 8'h24; mem[6] = 8'h49; mem[7] = 8'hB6;
      mem[19'h40] = 8'h1C;

      idle_v = mk(1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0);

      // Row n = n cycles after reset release; row 1 is the first RUN cycle (h=0,v=0).
      // fbuf_base changes at row 5, mid-frame, and must not disturb the addresses.
      tbl[0]  = '{1'b1, 19'h00, mk(1'b0, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000)};
      tbl[1]  = '{1'b1, 19'h00, mk(1'b1, 19'h0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000)};
      tbl[2]  = '{1'b1, 19'h00, mk(1'b1, 19'h1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000)};
      tbl[3]  = '{1'b1, 19'h00, mk(1'b1, 19'h2, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000)};
      tbl[4]  = '{1'b1, 19'h00, mk(1'b1, 19'h3, 1'b1, 1'b1, 1'b1, 1'b1, 24'hFF0000)};
      tbl[5]  = '{1'b1, 19'h55, mk(1'b1, 19'h4, 1'b1, 1'b0, 1'b1, 1'b1, 24'h00FF00)};
      tbl[6]  = '{1'b1, 19'h55, mk(1'b1, 19'h5, 1'b1, 1'b0, 1'b1, 1'b1, 24'h0000FF)};
      tbl[7]  = '{1'b1, 19'h55, mk(1'b1, 19'h6, 1'b1, 1'b0, 1'b1, 1'b1, 24'hFFFFFF)};
      tbl[8]  = '{1'b1, 19'h55, mk(1'b1, 19'h7, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000000)};
      tbl[9]  = '{1'b1, 19'h55, mk(1'b0, 19'h7, 1'b1, 1'b0, 1'b1, 1'b1, 24'h242400)};
      tbl[10] = '{1'b1, 19'h55, mk(1'b0, 19'h7, 1'b1, 1'b0, 1'b1, 1'b1, 24'h494955)};
      tbl[11] = '{1'b1, 19'h55, mk(1'b0, 19'h7, 1'b1, 1'b0, 1'b1, 1'b1, 24'hB6B6AA)};
      tbl[12] = '{1'b1, 19'h55, mk(1'b0, 19'h7, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000)};
      tbl[13] = '{1'b1, 19'h55, mk(1'b0, 19'h7, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000)};
      tbl[14] = '{1'b1, 19'h55, mk(1'b0, 19'h7, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000)};
      tbl[15] = '{1'b1, 19'h55, mk(1'b1, 19'h8, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000)};

      // Reset held: outputs idle every cycle.
      for (int i = 0; i < 10; i++) begin
         tick();
         sample();
         chk("reset_idle", outv(), idle_v);
      end

      // Release with enable=1 and walk the first line against the table.
      @(posedge clk);
      #1;
      cyc = 0;
      aresetn = 1'b1;
      for (int r = 0; r < 16; r++) begin
         if (r > 0) tick();
         enable    = tbl[r].en_in;
         fbuf_base = tbl[r].base_in;
         sample();
         chk($sformatf("first_line_row%0d", r), outv(), tbl[r].exp);
      end

      // One full frame period (98 cycles): raster counts and new base at frame 2 start.
      hs14 = 0; hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0;
      for (int i = 0; i < 98; i++) begin
         tick();
         sample();
         if (bus.vid_hsync == 1'b0) begin
            hs_low++;
            if (i < 14) hs14++;
         end
         if (bus.vid_vsync == 1'b0) vs_low++;
         if (bus.vid_de) de_cnt++;
         if (bus.frame_start) begin
            fs_cnt++;
            chk("frame2_first_addr", 48'({en_log[cyc-3], addr_log[cyc-3]}), 48'({1'b1, 19'h55}));
         end
      end
      chk("hsync_low_per_line", 48'(hs14), 48'd2);
      chk("hsync_low_per_frame", 48'(hs_low), 48'd14);
      chk("vsync_low_per_frame", 48'(vs_low), 48'd14);
      chk("de_per_frame", 48'(de_cnt), 48'd32);
      chk("frame_start_per_frame", 48'(fs_cnt), 48'd1);

      // Cycle 114: base changes mid-frame 2 (v=1,h=1 -> offset 9); old base must hold.
      tick();
      fbuf_base = 19'h7FFFE;
      sample();
      chk("midframe_base_hold", 48'({bus.fbuf_en_rd, bus.fbuf_addr}), 48'({1'b1, 19'h5E}));

      // enable blips low and back inside frame 2: frame 3 must follow with no gap.
      while (cyc < 196) begin
         tick();
         if (cyc == 150) enable = 1'b0;
         if (cyc == 160) enable = 1'b1;
         sample();
      end

      // Frame 3 uses the new base and wraps modulo 2^19.
      for (int k = 0; k < 3; k++) begin
         tick();
         if (cyc == 199) enable = 1'b0;
         sample();
         chk($sformatf("base_wrap_%0d", k), 48'({bus.fbuf_en_rd, bus.fbuf_addr}),
             48'({1'b1, 19'h7FFFE + 19'(k)}));
      end

      // enable now low: frame 3 still completes (ends at cycle 294), then idle.
      while (cyc < 305) begin
         tick();
         sample();
         if (cyc == 280) chk("vsync_in_last_frame", 48'(bus.vid_vsync), 48'd0);
         if (cyc == 295) chk("frame_tail_hsync", 48'({bus.fbuf_en_rd, bus.vid_hsync}), 48'd0);
         if (cyc >= 296) chk("idle_after_frame", outv(), idle_v);
      end

      // Restart, then reset pulse mid-line while the first pixel is on the output.
      tick();
      enable    = 1'b1;
      fbuf_base = 19'h10;
      sample();
      tick();
      sample();
      chk("restart_addr", 48'({bus.fbuf_en_rd, bus.fbuf_addr}), 48'({1'b1, 19'h10}));
      tick(); sample();
      tick(); sample();
      tick();
      aresetn = 1'b0;
      sample();
      chk("reset_async_idle", outv(), idle_v);
      tick();
      sample();
      chk("reset_hold_idle", outv(), idle_v);
      tick();
      aresetn   = 1'b1;
      fbuf_base = 19'h40;
      sample();
      chk("release_idle", outv(), idle_v);
      for (int k = 0; k < 3; k++) begin
         tick();
         sample();
         chk($sformatf("post_reset_addr_%0d", k), 48'({bus.fbuf_en_rd, bus.fbuf_addr}),
             48'({1'b1, 19'h40 + 19'(k)}));
      end
      tick();
      sample();
      chk("post_reset_first_pixel", outv(),
          mk(1'b1, 19'h43, 1'b1, 1'b1, 1'b1, 1'b1, 24'h00FF00));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
